// File: rtl/linebuffer_window_pkg.sv
// Shared constants and types for the streaming KxK window generator and the
// inner-product stage that consumes its flattened window.
package linebuffer_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 9;
  localparam int PIX_W = 7;
  localparam int WIN_N = K * K;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t             win_t [0:WIN_N-1];
  typedef logic [COL_W-1:0] col_t;
  typedef logic [ROW_W-1:0] row_t;

endpackage

// File: rtl/linebuffer_window_if.sv
// Pixel-in / window-out bundle: the master feeds raster pixels and receives
// windows, the slave (the window generator) does the opposite.
interface linebuffer_window_if;
  import linebuffer_pkg::*;

  pix_t pix_in;
  logic pix_valid;
  logic sof;
  win_t xarray;
  logic win_valid;
  row_t win_row;
  col_t win_col;

  modport master (
    output pix_in, pix_valid, sof,
    input  xarray, win_valid, win_row, win_col
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output xarray, win_valid, win_row, win_col
  );

endinterface

// File: rtl/linebuffer_window_line_delay.sv
// One image line of delay: a circular RAM whose single pointer is both the
// read and the write address, so dout is the sample written DEPTH enables ago.
module line_delay
  import linebuffer_pkg::*;
#(
  parameter int DEPTH = IMG_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  pix_t din,
  output pix_t dout
);

  localparam int PTR_W = $clog2(DEPTH);

  pix_t             mem_q [0:DEPTH-1];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Contents are deliberately never cleared; the top's row count masks stale data.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
  end

  assign dout = mem_q[ptr_q];

endmodule

// File: rtl/linebuffer_window.sv
// Raster-order KxK window generator: line-delay chain, position counters and
// a shifting window register with a one-cycle registered output.
module linebuffer_window
  import linebuffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  linebuffer_window_if.slave   bus
);

  col_t col_cnt_q, col_cnt_d;
  row_t row_cnt_q, row_cnt_d;
  win_t xarray_q, xarray_d;
  logic win_valid_q, win_valid_d;
  row_t win_row_q, win_row_d;
  col_t win_col_q, win_col_d;

  col_t cur_col;
  row_t cur_row;
  logic shift_en;

  pix_t chain_in [0:K-2];
  pix_t tap      [0:K-2];
  pix_t col_vec  [0:K-1];

  assign shift_en = bus.pix_valid && !rst;

  // tap[i] is the pixel (i+1) lines above the incoming one.
  genvar i;
  generate
    for (i = 0; i < K - 1; i++) begin : g_lines
      if (i == 0) begin : g_first
        assign chain_in[i] = bus.pix_in;
      end else begin : g_rest
        assign chain_in[i] = tap[i-1];
      end
      line_delay #(.DEPTH(IMG_W)) u_line (
        .clk  (clk),
        .rst  (rst),
        .en   (shift_en),
        .din  (chain_in[i]),
        .dout (tap[i])
      );
    end
  endgenerate

  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      col_vec[r] = tap[K-2-r];
    end
    col_vec[K-1] = bus.pix_in;
  end

  // sof forces the accepted pixel to (0,0) regardless of the running count.
  always_comb begin
    cur_col = bus.sof ? '0 : col_cnt_q;
    cur_row = bus.sof ? '0 : row_cnt_q;

    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    xarray_d    = xarray_q;
    win_valid_d = 1'b0;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;

    if (bus.pix_valid) begin
      if (cur_col == col_t'(IMG_W - 1)) begin
        col_cnt_d = '0;
        row_cnt_d = (cur_row == row_t'(IMG_H - 1)) ? '0 : cur_row + row_t'(1);
      end else begin
        col_cnt_d = cur_col + col_t'(1);
        row_cnt_d = cur_row;
      end

      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          xarray_d[r*K + c] = xarray_q[r*K + c + 1];
        end
        xarray_d[r*K + K - 1] = col_vec[r];
      end

      if (cur_row >= row_t'(K - 1) && cur_col >= col_t'(K - 1)) begin
        win_valid_d = 1'b1;
        win_row_d   = cur_row - row_t'(K - 1);
        win_col_d   = cur_col - col_t'(K - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_q   <= '0;
      row_cnt_q   <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      for (int k = 0; k < WIN_N; k++) begin
        xarray_q[k] <= '0;
      end
    end else begin
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      xarray_q    <= xarray_d;
    end
  end

  assign bus.xarray    = xarray_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;

endmodule

// File: tb/tb_linebuffer_window.sv
// Self-checking bench: ramp frames with random stalls, resyncs and resets,
// checked against an image-array model indexed by frame position.
module tb_linebuffer_window;
  import linebuffer_pkg::*;

  logic clk = 1'b0;
  logic rst;

  linebuffer_window_if bus ();

  linebuffer_window dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int win_cnt  = 0;

  pix_t img [0:IMG_H-1][0:IMG_W-1];
  int   m_row, m_col;
  logic exp_valid;
  int   exp_row, exp_col;
  win_t exp_win;
  bit   exp_known;

  function automatic pix_t ramp(input int r, input int c);
    ramp = pix_t'((r * IMG_W + c) % 128);
  endfunction

  task automatic model_reset();
    m_row = 0;
    m_col = 0;
    exp_valid = 1'b0;
    exp_row = 0;
    exp_col = 0;
    for (int k = 0; k < WIN_N; k++) exp_win[k] = '0;
    exp_known = 1'b1;
  endtask

  // Drives one clock of stimulus and advances the position-indexed model.
  task automatic drive_cycle(input logic v, input pix_t p, input logic s);
    int pr, pc;
    rst = 1'b0;
    bus.pix_valid = v;
    bus.pix_in = p;
    bus.sof = s;
    @(posedge clk);
    #1;
    if (v) begin
      pr = s ? 0 : m_row;
      pc = s ? 0 : m_col;
      img[pr][pc] = p;
      if (pr >= K - 1 && pc >= K - 1) begin
        exp_valid = 1'b1;
        exp_row = pr - (K - 1);
        exp_col = pc - (K - 1);
        for (int k = 0; k < WIN_N; k++)
          exp_win[k] = img[exp_row + k / K][exp_col + k % K];
        exp_known = 1'b1;
      end else begin
        exp_valid = 1'b0;
        exp_known = 1'b0;
      end
      m_col = pc + 1;
      m_row = pr;
      if (m_col == IMG_W) begin
        m_col = 0;
        m_row = (pr == IMG_H - 1) ? 0 : pr + 1;
      end
    end else begin
      exp_valid = 1'b0;
    end
  endtask

  // Streams ramp pixels from (r0,c0) through (r1,c1), comparing every cycle.
  task automatic run_ramp(input int r0, input int c0, input int r1, input int c1,
                          input bit sof_first, input bit stall_en);
    int r, c, stalls, bad;
    bit first;
    r = r0;
    c = c0;
    first = 1'b1;
    forever begin
      stalls = 0;
      if (stall_en)
        while ($urandom_range(0, 1) == 1 && stalls < 8) stalls++;
      for (int s = 0; s <= stalls; s++) begin
        if (s == stalls)
          drive_cycle(1'b1, ramp(r, c), sof_first && first);
        else
          drive_cycle(1'b0, pix_t'($urandom), 1'($urandom));
        n_checks++;
        if (bus.win_valid !== exp_valid) begin
          n_fail++;
          $display("[TB] FAIL win_valid at pix (%0d,%0d): got %b want %b", r, c, bus.win_valid, exp_valid);
        end
        n_checks++;
        if (bus.win_row !== row_t'(exp_row) || bus.win_col !== col_t'(exp_col)) begin
          n_fail++;
          $display("[TB] FAIL win_pos at pix (%0d,%0d): got (%0d,%0d) want (%0d,%0d)",
                   r, c, bus.win_row, bus.win_col, exp_row, exp_col);
        end
        if (exp_known) begin
          bad = -1;
          for (int k = WIN_N - 1; k >= 0; k--)
            if (bus.xarray[k] !== exp_win[k]) bad = k;
          n_checks++;
          if (bad >= 0) begin
            n_fail++;
            $display("[TB] FAIL xarray at pix (%0d,%0d) slot %0d: got %0d want %0d",
                     r, c, bad, bus.xarray[bad], exp_win[bad]);
          end
        end
        if (bus.win_valid === 1'b1) win_cnt++;
      end
      first = 1'b0;
      if (r == r1 && c == c1) break;
      c++;
      if (c == IMG_W) begin
        c = 0;
        r = (r == IMG_H - 1) ? 0 : r + 1;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    bus.pix_valid = 1'b1;
    bus.sof = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pix_in = pix_t'($urandom);
      @(posedge clk);
      #1;
      bad = 0;
      for (int k = 0; k < WIN_N; k++) if (bus.xarray[k] !== '0) bad++;
      n_checks++;
      if (bus.win_valid !== 1'b0 || bad != 0 || bus.win_row !== '0 || bus.win_col !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_hold cycle %0d: valid=%b nonzero_slots=%0d row=%0d col=%0d want 0/0/0/0",
                 i, bus.win_valid, bad, bus.win_row, bus.win_col);
      end
    end
    model_reset();
    drive_cycle(1'b0, pix_t'($urandom), 1'b1);
    bad = 0;
    for (int k = 0; k < WIN_N; k++) if (bus.xarray[k] !== '0) bad++;
    n_checks++;
    if (bus.win_valid !== 1'b0 || bad != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: valid=%b nonzero_slots=%0d want 0/0", bus.win_valid, bad);
    end
    drive_cycle(1'b1, pix_t'($urandom), 1'b0);
    n_checks++;
    if (bus.win_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_first_pix: valid=%b want 0", bus.win_valid);
    end
  endtask

  task automatic test_ramp();
    win_cnt = 0;
    run_ramp(0, 0, 8, 7, 1'b1, 1'b0);
    n_checks++;
    if (win_cnt != 0) begin
      n_fail++;
      $display("[TB] FAIL ramp_early_windows: got %0d want 0", win_cnt);
    end
    run_ramp(8, 8, 8, 8, 1'b0, 1'b0);
    n_checks++;
    if (bus.win_valid !== 1'b1 || bus.win_row !== '0 || bus.win_col !== '0 ||
        bus.xarray[0] !== 7'd0 || bus.xarray[1] !== 7'd1 ||
        bus.xarray[9] !== 7'd28 || bus.xarray[80] !== 7'd104) begin
      n_fail++;
      $display("[TB] FAIL ramp_first_window: v=%b pos=(%0d,%0d) s0=%0d s1=%0d s9=%0d s80=%0d want 1 (0,0) 0 1 28 104",
               bus.win_valid, bus.win_row, bus.win_col, bus.xarray[0], bus.xarray[1],
               bus.xarray[9], bus.xarray[80]);
    end
    run_ramp(8, 9, 27, 27, 1'b0, 1'b0);
    n_checks++;
    if (win_cnt != 400) begin
      n_fail++;
      $display("[TB] FAIL ramp_window_count: got %0d want 400", win_cnt);
    end
  endtask

  task automatic test_stalls();
    win_cnt = 0;
    run_ramp(0, 0, 27, 27, 1'b1, 1'b1);
    n_checks++;
    if (win_cnt != 400) begin
      n_fail++;
      $display("[TB] FAIL stall_window_count: got %0d want 400", win_cnt);
    end
  endtask

  task automatic test_back_to_back();
    win_cnt = 0;
    run_ramp(0, 0, 27, 27, 1'b1, 1'b0);
    run_ramp(0, 0, 8, 8, 1'b0, 1'b0);
    n_checks++;
    if (bus.win_valid !== 1'b1 || bus.win_row !== '0 || bus.win_col !== '0 ||
        bus.xarray[0] !== 7'd0 || bus.xarray[9] !== 7'd28 || bus.xarray[80] !== 7'd104) begin
      n_fail++;
      $display("[TB] FAIL b2b_second_first_window: v=%b pos=(%0d,%0d) s0=%0d s9=%0d s80=%0d want 1 (0,0) 0 28 104",
               bus.win_valid, bus.win_row, bus.win_col, bus.xarray[0], bus.xarray[9], bus.xarray[80]);
    end
    run_ramp(8, 9, 27, 27, 1'b0, 1'b0);
    n_checks++;
    if (win_cnt != 800) begin
      n_fail++;
      $display("[TB] FAIL b2b_window_count: got %0d want 800", win_cnt);
    end
  endtask

  task automatic test_sof_resync();
    run_ramp(0, 0, 12, 4, 1'b1, 1'b0);
    win_cnt = 0;
    run_ramp(0, 0, 8, 7, 1'b1, 1'b1);
    n_checks++;
    if (win_cnt != 0) begin
      n_fail++;
      $display("[TB] FAIL resync_early_windows: got %0d want 0", win_cnt);
    end
    run_ramp(8, 8, 27, 27, 1'b0, 1'b0);
    n_checks++;
    if (win_cnt != 400) begin
      n_fail++;
      $display("[TB] FAIL resync_window_count: got %0d want 400", win_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    run_ramp(0, 0, 15, 19, 1'b1, 1'b0);
    rst = 1'b1;
    bus.pix_valid = 1'b1;
    bus.sof = 1'b0;
    bus.pix_in = ramp(15, 20);
    @(posedge clk);
    #1;
    model_reset();
    bad = 0;
    for (int k = 0; k < WIN_N; k++) if (bus.xarray[k] !== '0) bad++;
    n_checks++;
    if (bus.win_valid !== 1'b0 || bad != 0 || bus.win_row !== '0 || bus.win_col !== '0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: valid=%b nonzero_slots=%0d row=%0d col=%0d want 0/0/0/0",
               bus.win_valid, bad, bus.win_row, bus.win_col);
    end
    win_cnt = 0;
    run_ramp(0, 0, 8, 7, 1'b0, 1'b0);
    n_checks++;
    if (win_cnt != 0) begin
      n_fail++;
      $display("[TB] FAIL midreset_early_windows: got %0d want 0", win_cnt);
    end
    run_ramp(8, 8, 27, 27, 1'b0, 1'b1);
    n_checks++;
    if (win_cnt != 400) begin
      n_fail++;
      $display("[TB] FAIL midreset_window_count: got %0d want 400", win_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_in = '0;
    bus.sof = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_ramp();
    test_stalls();
    test_back_to_back();
    test_sof_resync();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/linebuffer_window.md
# linebuffer_window

Streaming window generator that sits directly upstream of the logistic-regression inner-product stage. It accepts one 7-bit pixel per cycle in raster order and keeps K-1 previous image lines in line buffers. For every pixel position where a full KxK neighbourhood exists, it presents a registered, flattened KxK window to the combinational inner-product block, with stride 1.

## Interface
Parameters:
- IMG_W, 28: image width in pixels.
- IMG_H, 28: image height in lines.
- K, 9: window side. Window holds K*K = 81 slots.
- PIX_W, 7: pixel width.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  PIX_W  incoming pixel, raster order, row-major.
- pix_valid  in  1  pix_in is accepted this cycle when high. No backpressure.
- sof  in  1  start of frame; meaningful only when pix_valid is high; marks that pixel as (row 0, col 0).
- xarray  out  PIX_W x [0:K*K-1]  window slots; slot k = r*K + c. Row r=0 is the oldest line, c=0 the leftmost column.
- win_valid  out  1  xarray holds a complete window this cycle.
- win_row  out  $clog2(IMG_H)  image row of window slot 0.
- win_col  out  $clog2(IMG_W)  image column of window slot 0.

## Operation
- **Position counters.** col_cnt and row_cnt track the position of the pixel accepted this cycle.
  - Each accepted pixel increments col_cnt.
  - At col_cnt = IMG_W-1, col_cnt wraps to 0 and row_cnt increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0, which starts the next frame implicitly.
  - Accepted pixel with sof=1 is taken as position (0,0), whatever the counters hold. This is a resync; counters continue from (0,1).
- **Line buffers.** A chain of K-1 delay lines, each IMG_W deep and PIX_W wide.
  - They advance only on accepted pixels.
  - Taps give the column vector {row-8 ... row} at the current column.
  - Line-buffer contents are not cleared by rst or sof. Stale data is never flagged valid, because validity depends on row_cnt >= K-1.
- **Window register.** A KxK register array. On each accepted pixel, all columns shift left by one and column K-1 loads the new column vector. Row ordering is oldest at r=0, current pixel at slot K*K-1.
- **Valid rule.** win_valid=1 in the cycle after accepting a pixel with row_cnt >= K-1 and col_cnt >= K-1. In that cycle:
  - win_row = row_cnt-(K-1);
  - win_col = col_cnt-(K-1).
- **Windows per frame.** (IMG_H-K+1)*(IMG_W-K+1) = 400.
  - Windows never straddle a line wrap: columns 0..K-2 of each row give no valid output.
- **Stall.** pix_valid=0 means:
  - no state change;
  - next cycle win_valid=0;
  - xarray, win_row and win_col hold their last values.
- **Slot 0.** Always carries the real top-left pixel. The downstream stage ignores slot 0 (bias slot); this block does not zero it.

## Timing
- **Reset values** (the cycle after rst is sampled high):
  - xarray all 0, win_valid 0, win_row 0, win_col 0;
  - col_cnt = row_cnt = 0.
- **rst priority.** rst overrides pix_valid and sof in the same cycle.
- **Reset mid-frame.** Discards position. The next accepted pixel is treated as (0,0), and the first window comes 8 full rows later.
- **Latency.** One cycle from accepting the completing pixel to win_valid and xarray. All outputs are registered.
- **Throughput.** One pixel per cycle sustained. Arbitrary pix_valid gaps are allowed.
- **sof together with a completing pixel.** sof wins: the position is (0,0), so no window is produced.

## Structure
- **Package linebuffer_pkg:**
  - PIX_W, K, WIN_N = K*K, IMG_W, IMG_H;
  - typedef pix_t (PIX_W bits);
  - typedef win_t (pix_t array [0:WIN_N-1]), which is shared with the inner-product stage.
- **Sub-module line_delay:** parameter DEPTH = IMG_W.
  - Implemented as a circular RAM plus a write/read pointer, advanced by an enable.
  - Instantiated K-1 times in a chain.
- **Top level:** the counters, window shift array and valid logic.

## Test plan
- **Reset.** Assert rst for 3 cycles with pix_valid=1 -> xarray all 0, win_valid 0 throughout, and on the first cycle after release.
- **Ramp frame.** Drive pix = (r*28+c) mod 128, continuous, with sof on the first pixel. Expect:
  - first win_valid the cycle after pixel (8,8), with win_row=0, win_col=0;
  - slot 0 = 0, slot 1 = 1, slot 9 = 28, slot 80 = 104;
  - exactly 400 valid windows;
  - no valid in columns 0..7 of any row.
- **Stalls.** Same ramp with a random 50% pix_valid duty -> identical window sequence and values. win_valid is never high in a cycle following pix_valid=0.
- **Back-to-back frames.** Two ramp frames with no gap and no sof on the second -> 800 windows, with the second frame's first window equal to the first frame's.
- **sof resync.** Assert sof at position (12,5) mid-frame -> counters restart, no valid for 8 rows plus 8 columns. After that the window contents match a fresh frame.
- **Reset mid-frame.** Pulse rst at (15,20), then restart the ramp -> outputs 0 after reset, and the first window appears after 8 rows plus 8 pixels with the correct values.
